// File: rtl/iopmp_err_capture_pkg.sv
// rtl/iopmp_err_capture_pkg.sv - shared types and constants for the IOPMP error capture block
// Holds source width, access-type enum, error-type codes, the error record and FSM states.
package iopmp_err_capture_pkg;

  localparam int SourceWidth = 4;

  typedef enum logic [1:0] {
    IOPMP_ACC_NONE  = 2'd0,
    IOPMP_ACC_READ  = 2'd1,
    IOPMP_ACC_WRITE = 2'd2,
    IOPMP_ACC_EXEC  = 2'd3
  } iopmp_req_e;

  localparam logic [2:0] IOPMP_ETYPE_NONE = 3'd0;
  localparam logic [2:0] IOPMP_ETYPE_RD   = 3'd1;
  localparam logic [2:0] IOPMP_ETYPE_WR   = 3'd2;

  typedef struct packed {
    logic [33:0]            addr;
    logic [2:0]             etype;
    logic [SourceWidth-1:0] rrid;
  } err_record_t;

  typedef enum logic {
    ERR_EMPTY    = 1'b0,
    ERR_CAPTURED = 1'b1
  } err_state_t;

  function automatic logic [2:0] etype_of(input iopmp_req_e acc);
    case (acc)
      IOPMP_ACC_READ:  etype_of = IOPMP_ETYPE_RD;
      IOPMP_ACC_WRITE: etype_of = IOPMP_ETYPE_WR;
      default:         etype_of = IOPMP_ETYPE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/iopmp_err_rr_arb.sv
// rtl/iopmp_err_rr_arb.sv - round-robin arbiter over per-channel violation events
// Search starts at the pointer; pointer moves to winner+1 only when something is granted.
module iopmp_err_rr_arb #(
  parameter int NumReq = 2,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req_i,
  output logic              gnt_valid_o,
  output logic [NumReq-1:0] gnt_oh_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

  logic [IdxW-1:0] r_ptr;
  logic            w_valid;
  logic [IdxW-1:0] w_idx;
  logic [NumReq-1:0] w_oh;

  always_comb begin
    w_valid = 1'b0;
    w_idx   = '0;
    w_oh    = '0;
    for (int off = 0; off < NumReq; off++) begin
      int c;
      c = int'(r_ptr) + off;
      if (c >= NumReq) c = c - NumReq;
      if (!w_valid && req_i[c]) begin
        w_valid = 1'b1;
        w_idx   = IdxW'(c);
      end
    end
    if (w_valid) w_oh[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_valid) begin
      r_ptr <= (w_idx == IdxW'(NumReq - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign gnt_valid_o = w_valid;
  assign gnt_oh_o    = w_oh;
  assign gnt_idx_o   = w_idx;

endmodule

// File: rtl/iopmp_err_capture.sv
// rtl/iopmp_err_capture.sv - latches first IOPMP violation, counts later ones, raises level irq
// Optional per-RRID bitmap of counted violations when IOPMP_ERR_SVC_MAP_EN is defined.
module iopmp_err_capture
  import iopmp_err_capture_pkg::*;
#(
  parameter int IOPMPNumChan = 2,
  parameter int SvcCntWidth  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [IOPMPNumChan-1:0]                   viol_i,
  input  logic [IOPMPNumChan-1:0][33:0]             viol_addr_i,
  input  iopmp_req_e [IOPMPNumChan-1:0]             viol_acc_i,
  input  logic [IOPMPNumChan-1:0][SourceWidth-1:0]  viol_rrid_i,
  input  logic                                      intr_en_i,
  input  logic                                      err_clr_i,
  output logic                                      err_valid_o,
  output logic [33:0]                               err_addr_o,
  output logic [2:0]                                err_type_o,
  output logic [SourceWidth-1:0]                    err_rrid_o,
  output logic [SvcCntWidth-1:0]                    err_svc_cnt_o,
  output logic                                      err_irq_o
`ifdef IOPMP_ERR_SVC_MAP_EN
  ,
  output logic [2**SourceWidth-1:0]                 err_svc_map_o
`endif
);

  localparam int IdxW = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1;

  logic [IOPMPNumChan-1:0] r_viol_q;
  logic [IOPMPNumChan-1:0] w_evt;
  logic [IOPMPNumChan-1:0] w_gnt_oh;
  logic [IOPMPNumChan-1:0] w_count_mask;
  logic [IdxW-1:0]         w_gnt_idx;
  logic                    w_gnt_valid;
  err_state_t              r_state, w_state_nxt;
  err_record_t             r_rec, w_rec_nxt;
  logic [SvcCntWidth-1:0]  r_cnt, w_cnt_nxt, w_cnt_base;
  logic [SvcCntWidth:0]    w_cnt_sum;
  logic                    r_irq;
  logic                    w_capture;
  logic                    w_clear;

  // A held violation line counts once: only rising edges are events.
  assign w_evt = viol_i & ~r_viol_q;

  iopmp_err_rr_arb #(
    .NumReq (IOPMPNumChan),
    .IdxW   (IdxW)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (w_evt),
    .gnt_valid_o (w_gnt_valid),
    .gnt_oh_o    (w_gnt_oh),
    .gnt_idx_o   (w_gnt_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    w_count_mask = '0;
    case (r_state)
      ERR_EMPTY: begin
        if (w_gnt_valid) begin
          w_capture    = 1'b1;
          w_count_mask = w_evt & ~w_gnt_oh;
          w_state_nxt  = ERR_CAPTURED;
        end
      end
      ERR_CAPTURED: begin
        if (err_clr_i) begin
          w_clear = 1'b1;
          if (w_gnt_valid) begin
            w_capture    = 1'b1;
            w_count_mask = w_evt & ~w_gnt_oh;
          end else begin
            w_state_nxt = ERR_EMPTY;
          end
        end else begin
          w_count_mask = w_evt;
        end
      end
      default: w_state_nxt = ERR_EMPTY;
    endcase
  end

  always_comb begin
    w_rec_nxt = r_rec;
    if (w_clear) w_rec_nxt = '0;
    if (w_capture) begin
      w_rec_nxt.addr  = viol_addr_i[w_gnt_idx];
      w_rec_nxt.etype = etype_of(viol_acc_i[w_gnt_idx]);
      w_rec_nxt.rrid  = viol_rrid_i[w_gnt_idx];
    end
    w_cnt_base = w_clear ? '0 : r_cnt;
    w_cnt_sum  = {1'b0, w_cnt_base} + (SvcCntWidth + 1)'($countones(w_count_mask));
    w_cnt_nxt  = w_cnt_sum[SvcCntWidth] ? '1 : w_cnt_sum[SvcCntWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ERR_EMPTY;
      r_rec    <= '0;
      r_cnt    <= '0;
      r_viol_q <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rec    <= w_rec_nxt;
      r_cnt    <= w_cnt_nxt;
      r_viol_q <= viol_i;
      r_irq    <= (w_state_nxt == ERR_CAPTURED) & intr_en_i;
    end
  end

  assign err_valid_o   = (r_state == ERR_CAPTURED);
  assign err_addr_o    = r_rec.addr;
  assign err_type_o    = r_rec.etype;
  assign err_rrid_o    = r_rec.rrid;
  assign err_svc_cnt_o = r_cnt;
  assign err_irq_o     = r_irq;

`ifdef IOPMP_ERR_SVC_MAP_EN
  logic [2**SourceWidth-1:0] r_map, w_map_nxt;

  always_comb begin
    w_map_nxt = w_clear ? '0 : r_map;
    for (int i = 0; i < IOPMPNumChan; i++) begin
      if (w_count_mask[i]) w_map_nxt[viol_rrid_i[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_map <= '0;
    else     r_map <= w_map_nxt;
  end

  assign err_svc_map_o = r_map;
`endif

endmodule

// File: tb/tb_iopmp_err_capture.sv
// tb/tb_iopmp_err_capture.sv - directed self-checking bench for iopmp_err_capture
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_iopmp_err_capture;
  import iopmp_err_capture_pkg::*;

  logic                           clk;
  logic                           rst;
  logic [1:0]                     viol;
  logic [1:0][33:0]               addr;
  iopmp_req_e [1:0]               acc;
  logic [1:0][SourceWidth-1:0]    rrid;
  logic                           intr_en;
  logic                           err_clr;
  logic                           err_valid;
  logic [33:0]                    err_addr;
  logic [2:0]                     err_type;
  logic [SourceWidth-1:0]         err_rrid;
  logic [7:0]                     err_cnt;
  logic                           err_irq;
`ifdef IOPMP_ERR_SVC_MAP_EN
  logic [2**SourceWidth-1:0]      err_map;
`endif

  int n_chk = 0;
  int n_err = 0;

  iopmp_err_capture #(.IOPMPNumChan(2), .SvcCntWidth(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .viol_i        (viol),
    .viol_addr_i   (addr),
    .viol_acc_i    (acc),
    .viol_rrid_i   (rrid),
    .intr_en_i     (intr_en),
    .err_clr_i     (err_clr),
    .err_valid_o   (err_valid),
    .err_addr_o    (err_addr),
    .err_type_o    (err_type),
    .err_rrid_o    (err_rrid),
    .err_svc_cnt_o (err_cnt),
    .err_irq_o     (err_irq)
`ifdef IOPMP_ERR_SVC_MAP_EN
    ,
    .err_svc_map_o (err_map)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rec(input string tag, input logic v, input logic [33:0] a,
                         input logic [2:0] t, input logic [3:0] r, input logic [7:0] c);
    chk({tag, ".valid"}, 64'(err_valid), 64'(v));
    chk({tag, ".addr"},  64'(err_addr),  64'(a));
    chk({tag, ".type"},  64'(err_type),  64'(t));
    chk({tag, ".rrid"},  64'(err_rrid),  64'(r));
    chk({tag, ".cnt"},   64'(err_cnt),   64'(c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; viol = '0; intr_en = 1'b0; err_clr = 1'b0;
    addr[0] = 34'h0_8000_0010; acc[0] = IOPMP_ACC_READ;  rrid[0] = 4'd0;
    addr[1] = 34'h0_2000_0004; acc[1] = IOPMP_ACC_WRITE; rrid[1] = 4'd3;
    do_reset();
    chk_rec("reset", 1'b0, 34'h0, 3'd0, 4'd0, 8'd0);
    chk("reset.irq", 64'(err_irq), 64'd0);

    // Single read violation on ch0
    intr_en = 1'b1;
    viol = 2'b01;
    tick();
    viol = 2'b00;
    chk_rec("single", 1'b1, 34'h0_8000_0010, 3'd1, 4'd0, 8'd0);
    chk("single.irq", 64'(err_irq), 64'd1);

    // Round robin from a fresh pointer
    do_reset();
    viol = 2'b11;
    tick();
    viol = 2'b00;
    chk_rec("rr0", 1'b1, 34'h0_8000_0010, 3'd1, 4'd0, 8'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_rec("clr", 1'b0, 34'h0, 3'd0, 4'd0, 8'd0);
    chk("clr.irq", 64'(err_irq), 64'd0);
    viol = 2'b11;
    tick();
    viol = 2'b00;
    chk_rec("rr1", 1'b1, 34'h0_2000_0004, 3'd2, 4'd3, 8'd1);

    // Saturating counter with record frozen
    for (int i = 0; i < 300; i++) begin
      viol = 2'b01;
      tick();
      viol = 2'b00;
      tick();
    end
    chk_rec("sat", 1'b1, 34'h0_2000_0004, 3'd2, 4'd3, 8'd255);

    // Held line counts once
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    viol = 2'b10;
    for (int i = 0; i < 10; i++) tick();
    chk_rec("held", 1'b1, 34'h0_2000_0004, 3'd2, 4'd3, 8'd0);
    viol = 2'b00;
    tick();

    // Clear and new event on the same edge
    addr[1] = 34'h0_1000_0000; rrid[1] = 4'd5;
    err_clr = 1'b1;
    viol = 2'b10;
    tick();
    err_clr = 1'b0;
    viol = 2'b00;
    chk_rec("clr_evt", 1'b1, 34'h0_1000_0000, 3'd2, 4'd5, 8'd0);

    // Two events in one cycle while captured
    tick();
    viol = 2'b11;
    tick();
    viol = 2'b00;
    chk_rec("pop2", 1'b1, 34'h0_1000_0000, 3'd2, 4'd5, 8'd2);

    // Interrupt enable gating
    chk("irq.on", 64'(err_irq), 64'd1);
    intr_en = 1'b0;
    tick();
    chk("irq.off", 64'(err_irq), 64'd0);
    chk("irq.off.valid", 64'(err_valid), 64'd1);
    intr_en = 1'b1;
    tick();
    chk("irq.reon", 64'(err_irq), 64'd1);

    // Reset while captured
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rec("midrst", 1'b0, 34'h0, 3'd0, 4'd0, 8'd0);
    chk("midrst.irq", 64'(err_irq), 64'd0);

    // Clear in EMPTY does nothing; non read/write access maps to type 0
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_empty.valid", 64'(err_valid), 64'd0);
    acc[0] = IOPMP_ACC_EXEC;
    viol = 2'b01;
    tick();
    viol = 2'b00;
    chk_rec("exec", 1'b1, 34'h0_8000_0010, 3'd0, 4'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
